gam_winner_search: RTL and testbench

Winner/runner-up search stage of the GAM memory layer. For one class, it scans the stored node weight vectors `W[1..node_count]`, computes the distance of each from the input vector `X`, and reports the nearest node (winner) and second-nearest node (runner-up). It sits directly upstream of the node-insertion, weight-update and connection-age logic, which consume its result.

---
 rtl/gam_winner_search_if.sv | 37 +++
 rtl/gam_winner_search.sv | 167 ++++++++++++++++
 tb/tb_gam_winner_search.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gam_winner_search_if.sv
// Request/result and node-memory read bus of the GAM winner/runner-up search.
// DIST_W follows the GAM_SQ_DIST_EN build option so both ends agree on width.
interface gam_winner_search_if #(
  parameter int NODE_COUNT = 10,
  parameter int VECTOR_LEN = 4,
  parameter int IDX_W      = $clog2(NODE_COUNT) + 1,
`ifdef GAM_SQ_DIST_EN
  parameter int DIST_W     = 16 + $clog2(VECTOR_LEN)
`else
  parameter int DIST_W     = 8 + $clog2(VECTOR_LEN)
`endif
);
  logic                    start;
  logic [VECTOR_LEN*8-1:0] x_vec;
  logic [IDX_W-1:0]        node_cnt;
  logic                    rd_en;
  logic [IDX_W-1:0]        rd_addr;
  logic [VECTOR_LEN*8-1:0] rd_w;
  logic                    rd_invalid;
  logic                    busy;
  logic                    done;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        sec_idx;
  logic [DIST_W-1:0]       win_dist;
  logic [DIST_W-1:0]       sec_dist;

  // master: the requester that also serves node memory; slave: the search engine
  modport master (
    output start, x_vec, node_cnt, rd_w, rd_invalid,
    input  rd_en, rd_addr, busy, done, win_idx, sec_idx, win_dist, sec_dist
  );

  modport slave (
    input  start, x_vec, node_cnt, rd_w, rd_invalid,
    output rd_en, rd_addr, busy, done, win_idx, sec_idx, win_dist, sec_dist
  );
endinterface

// File: rtl/gam_winner_search.sv
// GAM winner/runner-up search: scans node weights, ranks them by distance to X.
// Build option GAM_SQ_DIST_EN selects squared Euclidean distance instead of Manhattan.
module gam_winner_search #(
  parameter int NODE_COUNT = 10,
  parameter int VECTOR_LEN = 4,
  parameter int IDX_W      = $clog2(NODE_COUNT) + 1,
`ifdef GAM_SQ_DIST_EN
  parameter int DIST_W     = 16 + $clog2(VECTOR_LEN)
`else
  parameter int DIST_W     = 8 + $clog2(VECTOR_LEN)
`endif
) (
  input logic               clk,
  input logic               rst_n,
  gam_winner_search_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int VEC_W  = VECTOR_LEN * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   k;
  logic [IDX_W-1:0]   cnt_lat;
  logic [VEC_W-1:0]   x_lat;
  logic               accept;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_addr;

  logic               vld_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [DIST_W-1:0]  dist_p1;
  logic               hit_p1;

  logic [DIST_W-1:0]  b1_dist, b2_dist, b1_dist_nxt, b2_dist_nxt;
  logic [IDX_W-1:0]   b1_idx, b2_idx, b1_idx_nxt, b2_idx_nxt;

  logic [IDX_W-1:0]   win_idx_q, sec_idx_q;
  logic [DIST_W-1:0]  win_dist_q, sec_dist_q;

  function automatic logic [DIST_W-1:0] dist_fn(input logic [VEC_W-1:0] x,
                                                input logic [VEC_W-1:0] w);
    logic [DIST_W-1:0]  acc;
    logic signed [8:0]  diff;
    logic [7:0]         ad;
`ifdef GAM_SQ_DIST_EN
    logic [15:0]        sq;
`endif
    acc = '0;
    for (int i = 0; i < VECTOR_LEN; i++) begin
      diff = $signed({1'b0, x[DATA_W*i +: DATA_W]}) - $signed({1'b0, w[DATA_W*i +: DATA_W]});
      ad   = diff[8] ? 8'(-diff) : diff[7:0];
`ifdef GAM_SQ_DIST_EN
      sq   = 16'(ad) * 16'(ad);
      acc  = acc + DIST_W'(sq);
`else
      acc  = acc + DIST_W'(ad);
`endif
    end
    return acc;
  endfunction

  function automatic logic [IDX_W-1:0] clamp_cnt(input logic [IDX_W-1:0] n);
    return (n > IDX_W'(NODE_COUNT)) ? IDX_W'(NODE_COUNT) : n;
  endfunction

  assign accept  = (state == S_IDLE) && bus.start;
  assign rd_en   = (state == S_SCAN);
  assign rd_addr = rd_en ? k : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = (bus.node_cnt == '0) ? S_DONE : S_SCAN;
      S_SCAN:  if (k == cnt_lat) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      cnt_lat <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (accept) begin
        k       <= IDX_W'(1);
        cnt_lat <= clamp_cnt(bus.node_cnt);
      end else if (rd_en) begin
        k <= k + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) x_lat <= bus.x_vec;
    idx_p1 <= rd_addr;
  end

  // Stage p1: read data returns; distance and ranking against the running best two
  assign dist_p1 = dist_fn(x_lat, bus.rd_w);
  assign hit_p1  = vld_p1 && !bus.rd_invalid;

  always_comb begin
    b1_dist_nxt = b1_dist;
    b1_idx_nxt  = b1_idx;
    b2_dist_nxt = b2_dist;
    b2_idx_nxt  = b2_idx;
    if (accept) begin
      b1_dist_nxt = '1;
      b1_idx_nxt  = '0;
      b2_dist_nxt = '1;
      b2_idx_nxt  = '0;
    end else if (hit_p1) begin
      // strict compare keeps the earlier (lower) index on ties
      if (dist_p1 < b1_dist) begin
        b2_dist_nxt = b1_dist;
        b2_idx_nxt  = b1_idx;
        b1_dist_nxt = dist_p1;
        b1_idx_nxt  = idx_p1;
      end else if (dist_p1 < b2_dist) begin
        b2_dist_nxt = dist_p1;
        b2_idx_nxt  = idx_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    b1_dist <= b1_dist_nxt;
    b1_idx  <= b1_idx_nxt;
    b2_dist <= b2_dist_nxt;
    b2_idx  <= b2_idx_nxt;
  end

  // Results load on entry to DONE from the post-compare values, so they are valid with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_idx_q  <= '0;
      sec_idx_q  <= '0;
      win_dist_q <= '0;
      sec_dist_q <= '0;
    end else if (state_nxt == S_DONE) begin
      win_idx_q  <= b1_idx_nxt;
      sec_idx_q  <= b2_idx_nxt;
      win_dist_q <= (b1_idx_nxt == '0) ? '0 : b1_dist_nxt;
      sec_dist_q <= (b2_idx_nxt == '0) ? '0 : b2_dist_nxt;
    end
  end

  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_addr;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.win_idx  = win_idx_q;
  assign bus.sec_idx  = sec_idx_q;
  assign bus.win_dist = win_dist_q;
  assign bus.sec_dist = sec_dist_q;

endmodule

// File: tb/tb_gam_winner_search.sv
// Scoreboard bench for gam_winner_search: a ranking model predicts each search, a
// negedge monitor checks results, latency, read sequence, busy and result hold.
module tb_gam_winner_search;
  localparam int NC = 10;
  localparam int VL = 4;
  localparam int VW = VL * 8;

  typedef struct {
    int wi, wd, si, sd;
    int s_cyc, d_cyc, nreads;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_cnt = 0;
  exp_t q[$];
  exp_t hold;

  logic [VW-1:0] mem_w   [0:31];
  bit            mem_inv [0:31];
  logic [VW-1:0] x_cur;
  bit            pend;
  logic [4:0]    paddr;

  gam_winner_search_if bus ();

  gam_winner_search dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int pdist(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s = 0;
    for (int i = 0; i < VL; i++) begin
      int d = int'(a[8*i +: 8]) - int'(b[8*i +: 8]);
`ifdef GAM_SQ_DIST_EN
      s += d * d;
`else
      s += (d < 0) ? -d : d;
`endif
    end
    return s;
  endfunction

  // Rank each valid node by how many valid nodes beat it (smaller distance, or equal and lower index)
  function automatic exp_t ref_model(input int n);
    exp_t e;
    int   nn;
    int   d [0:NC];
    bit   ok [0:NC];
    e = '{default: 0};
    nn = (n > NC) ? NC : n;
    e.nreads = nn;
    for (int j = 0; j <= NC; j++) begin
      ok[j] = (j >= 1) && (j <= nn) && !mem_inv[j];
      d[j]  = pdist(x_cur, mem_w[j]);
    end
    for (int j = 1; j <= NC; j++) begin
      if (ok[j]) begin
        int rank = 0;
        for (int m = 1; m <= NC; m++)
          if (ok[m] && m != j && (d[m] < d[j] || (d[m] == d[j] && m < j))) rank++;
        if (rank == 0) begin e.wi = j; e.wd = d[j]; end
        if (rank == 1) begin e.si = j; e.sd = d[j]; end
      end
    end
    return e;
  endfunction

  // Caller is positioned just after a rising edge; start is high for this one cycle
  task automatic issue(input int n);
    exp_t e;
    e = ref_model(n);
    e.s_cyc = cyc;
    e.d_cyc = cyc + ((e.nreads == 0) ? 1 : e.nreads + 2);
    q.push_back(e);
    bus.x_vec    = x_cur;
    bus.node_cnt = 5'(n);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !bus.busy) break;
      @(posedge clk); #1;
    end
    chk("idle_after_search", int'(bus.busy) + q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     int'(bus.busy), 0);
    chk({tag, "_done"},     int'(bus.done), 0);
    chk({tag, "_rd_en"},    int'(bus.rd_en), 0);
    chk({tag, "_rd_addr"},  int'(bus.rd_addr), 0);
    chk({tag, "_win_idx"},  int'(bus.win_idx), 0);
    chk({tag, "_sec_idx"},  int'(bus.sec_idx), 0);
    chk({tag, "_win_dist"}, int'(bus.win_dist), 0);
    chk({tag, "_sec_dist"}, int'(bus.sec_dist), 0);
  endtask

  function automatic logic [7:0] small_pix();
    logic [7:0] tbl [4];
    tbl = '{8'd0, 8'd10, 8'd20, 8'd30};
    return tbl[$urandom_range(0, 3)];
  endfunction

  function automatic logic [VW-1:0] rand_vec(input bit coarse);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[8*i +: 8] = coarse ? small_pix() : 8'($urandom);
    return v;
  endfunction

  // Node memory: returns the addressed weight one cycle after rd_en, garbage otherwise
  always @(negedge clk) begin
    pend  = bus.rd_en;
    paddr = bus.rd_addr;
  end

  always @(posedge clk) begin
    #1;
    if (pend) begin
      bus.rd_w       = mem_w[paddr];
      bus.rd_invalid = mem_inv[paddr];
    end else begin
      bus.rd_w       = $urandom;
      bus.rd_invalid = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      hold   = '{default: 0};
    end else begin
      bit exp_busy;
      if (bus.rd_en) begin
        rd_cnt++;
        chk("rd_addr", int'(bus.rd_addr), rd_cnt);
      end
      exp_busy = 1'b0;
      if (q.size() > 0) exp_busy = (cyc > q[0].s_cyc) && (cyc <= q[0].d_cyc);
      chk("busy", int'(bus.busy), int'(exp_busy));
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("done_when_idle", int'(bus.done), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.d_cyc);
          chk("win_idx",  int'(bus.win_idx),  e.wi);
          chk("win_dist", int'(bus.win_dist), e.wd);
          chk("sec_idx",  int'(bus.sec_idx),  e.si);
          chk("sec_dist", int'(bus.sec_dist), e.sd);
          chk("rd_count", rd_cnt, e.nreads);
          rd_cnt = 0;
          hold   = e;
        end
      end else begin
        chk("hold_win_idx",  int'(bus.win_idx),  hold.wi);
        chk("hold_win_dist", int'(bus.win_dist), hold.wd);
        chk("hold_sec_idx",  int'(bus.sec_idx),  hold.si);
        chk("hold_sec_dist", int'(bus.sec_dist), hold.sd);
      end
    end
  end

  task automatic load_basic();
    for (int j = 0; j < 32; j++) begin
      mem_w[j]   = '0;
      mem_inv[j] = 1'b0;
    end
    x_cur    = {8'd10, 8'd10, 8'd10, 8'd10};
    mem_w[1] = {8'd0, 8'd0, 8'd0, 8'd0};
    mem_w[2] = {8'd12, 8'd10, 8'd10, 8'd10};
    mem_w[3] = {8'd20, 8'd20, 8'd20, 8'd20};
    mem_w[4] = {8'd30, 8'd30, 8'd30, 8'd30};
    mem_w[5] = {8'd11, 8'd9, 8'd10, 8'd10};
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.x_vec      = '0;
    bus.node_cnt   = '0;
    bus.rd_w       = '0;
    bus.rd_invalid = 1'b0;
    load_basic();

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3); wait_idle();                         // basic scan with tie on node 1/3
    mem_inv[2] = 1'b1;
    issue(3); wait_idle();                         // invalid node skipped
    mem_inv[2] = 1'b0;
    issue(0); wait_idle();                         // empty class
    mem_w[1] = x_cur;
    issue(1); wait_idle();                         // single node, exact match
    load_basic();

    issue(5);                                      // re-pulsed start mid-scan is ignored
    @(posedge clk); #1;
    bus.node_cnt = 5'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    wait_idle();

    issue(5);                                      // reset at cycle 2 of a 5-node scan
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_all_zero("midscan_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(3); wait_idle();

    issue(14); wait_idle();                        // node_cnt above NODE_COUNT is clamped

    for (int t = 0; t < 40; t++) begin
      bit coarse;
      coarse = ($urandom_range(0, 1) == 1);
      for (int j = 1; j <= NC; j++) begin
        mem_w[j]   = rand_vec(coarse);
        mem_inv[j] = ($urandom_range(0, 3) == 0);
      end
      x_cur = rand_vec(coarse);
      issue(int'($urandom_range(0, 14)));
      wait_idle();
    end

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
